// File: rtl/wb_slave_mux_pkg.sv
// wb_intercon_defines: shared FSM states, Wishbone burst codes and a clog2 helper.
package wb_intercon_defines;
  typedef enum logic [1:0] {IDLE, ACTIVE, DERR, TOUT} state_t;
  localparam logic [2:0] cti_classic = 3'b000;
  localparam logic [2:0] cti_const = 3'b001;
  localparam logic [2:0] cti_incr = 3'b010;
  localparam logic [2:0] cti_end = 3'b111;
  localparam logic [1:0] bte_linear = 2'b00;
  localparam logic [1:0] bte_wrap4 = 2'b01;
  localparam logic [1:0] bte_wrap8 = 2'b10;
  localparam logic [1:0] bte_wrap16 = 2'b11;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/wb_addr_decode.sv
// wb_addr_decode: address match/mask compare with lowest-index-wins priority.
module wb_addr_decode
  import wb_intercon_defines::*;
#(
  parameter int aw = 32,
  parameter int num_slaves = 2,
  parameter logic [num_slaves*aw-1:0] match_addr = '0,
  parameter logic [num_slaves*aw-1:0] match_mask = '0,
  localparam int iw = num_slaves > 1 ? clog2(num_slaves) : 1
) (
  input  logic [aw-1:0] adr,
  output logic          hit,
  output logic [iw-1:0] index
);
  always_comb begin
    hit = 1'b0;
    index = '0;
    for (int i = num_slaves - 1; i >= 0; i--)
      if ((adr & match_mask[i*aw +: aw]) == (match_addr[i*aw +: aw] & match_mask[i*aw +: aw])) begin
        hit = 1'b1;
        index = iw'(i);
      end
  end
endmodule

// File: rtl/wb_slave_mux.sv
// wb_slave_mux: routes one Wishbone master to one of num_slaves slaves, with decode-error and watchdog termination.
module wb_slave_mux
  import wb_intercon_defines::*;
#(
  parameter int dw = 32,
  parameter int aw = 32,
  parameter int num_slaves = 2,
  parameter logic [num_slaves*aw-1:0] match_addr = '0,
  parameter logic [num_slaves*aw-1:0] match_mask = '0,
  parameter int timeout_cycles = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic [aw-1:0]            wbm_adr_i,
  input  logic [dw-1:0]            wbm_dat_i,
  input  logic [3:0]               wbm_sel_i,
  input  logic                     wbm_we_i,
  input  logic                     wbm_cyc_i,
  input  logic                     wbm_stb_i,
  input  logic [2:0]               wbm_cti_i,
  input  logic [1:0]               wbm_bte_i,
  output logic [dw-1:0]            wbm_dat_o,
  output logic                     wbm_ack_o,
  output logic                     wbm_err_o,
  output logic                     wbm_rty_o,
  output logic [num_slaves*aw-1:0] wbs_adr_o,
  output logic [num_slaves*dw-1:0] wbs_dat_o,
  output logic [num_slaves*4-1:0]  wbs_sel_o,
  output logic [num_slaves-1:0]    wbs_we_o,
  output logic [num_slaves*3-1:0]  wbs_cti_o,
  output logic [num_slaves*2-1:0]  wbs_bte_o,
  output logic [num_slaves-1:0]    wbs_cyc_o,
  output logic [num_slaves-1:0]    wbs_stb_o,
  input  logic [num_slaves*dw-1:0] wbs_dat_i,
  input  logic [num_slaves-1:0]    wbs_ack_i,
  input  logic [num_slaves-1:0]    wbs_err_i,
  input  logic [num_slaves-1:0]    wbs_rty_i
);
  localparam int iw = num_slaves > 1 ? clog2(num_slaves) : 1;
  localparam int ww = timeout_cycles > 0 ? clog2(timeout_cycles + 1) : 1;
  localparam logic [ww-1:0] wd_max = ww'(timeout_cycles > 0 ? timeout_cycles - 1 : 0);
  state_t state;
  logic [iw-1:0] sel_q, idx, cur;
  logic [ww-1:0] wd;
  logic hit, req, route, drv, term, tmo;
  wb_addr_decode #(
    .aw(aw), .num_slaves(num_slaves), .match_addr(match_addr), .match_mask(match_mask)
  ) u_dec (
    .adr(wbm_adr_i), .hit(hit), .index(idx)
  );
  assign req = wbm_cyc_i & wbm_stb_i;
  assign route = state == IDLE && req && hit;
  // Reset gates the combinational strobe/response paths so they drop without a clock edge.
  assign drv = wb_rst_n_i && (state == ACTIVE || route);
  assign cur = state == ACTIVE ? sel_q : idx;
  assign term = drv && (wbs_ack_i[cur] | wbs_err_i[cur] | wbs_rty_i[cur]);
  assign tmo = timeout_cycles != 0 && drv && wbm_stb_i && !term && wd == wd_max;
  assign wbm_dat_o = drv ? wbs_dat_i[cur*dw +: dw] : '0;
  assign wbm_ack_o = drv & wbs_ack_i[cur];
  assign wbm_rty_o = drv & wbs_rty_i[cur];
  assign wbm_err_o = (drv & wbs_err_i[cur]) | (wb_rst_n_i & (state == DERR || state == TOUT));
  assign wbs_adr_o = {num_slaves{wbm_adr_i}};
  assign wbs_dat_o = {num_slaves{wbm_dat_i}};
  assign wbs_sel_o = {num_slaves{wbm_sel_i}};
  assign wbs_we_o = {num_slaves{wbm_we_i}};
  assign wbs_cti_o = {num_slaves{wbm_cti_i}};
  assign wbs_bte_o = {num_slaves{wbm_bte_i}};
  for (genvar i = 0; i < num_slaves; i++) begin : g_slv
    assign wbs_cyc_o[i] = drv && cur == iw'(i) && wbm_cyc_i;
    assign wbs_stb_o[i] = drv && cur == iw'(i) && wbm_stb_i;
  end
  // The routing cycle in IDLE already counts as the first watchdog cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      state <= IDLE;
      sel_q <= '0;
      wd <= '0;
    end else begin
      state <= tmo ? TOUT :
               route ? ACTIVE :
               state == IDLE && req ? DERR :
               state == ACTIVE && wbm_cyc_i ? ACTIVE : IDLE;
      if (route) sel_q <= idx;
      wd <= (!drv || !wbm_stb_i || term || tmo) ? '0 : wd + 1'b1;
    end
endmodule

// File: tb/tb_wb_slave_mux.sv
// tb_wb_slave_mux: directed vector table, reset corner case and random traffic against a transaction-level model.
module tb_wb_slave_mux;
  localparam int T = 8;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [31:0] adr = 0, mdat = 0;
  logic [3:0] sel = 0;
  logic we = 0, cyc = 0, stb = 0;
  logic [2:0] cti = 0;
  logic [1:0] bte = 0;
  logic [31:0] m_dat_o;
  logic m_ack, m_err, m_rty;
  logic [63:0] s_adr, s_dat_o;
  logic [7:0] s_sel;
  logic [1:0] s_we, s_cyc, s_stb;
  logic [5:0] s_cti;
  logic [3:0] s_bte;
  logic [63:0] sdat = {32'hDEADBEEF, 32'h0000_5EED};
  logic [1:0] sack = 0, serr = 0, srty = 0;

  wb_slave_mux #(
    .dw(32), .aw(32), .num_slaves(2),
    .match_addr({32'h1000_0000, 32'h0000_0000}),
    .match_mask({32'hF000_0000, 32'hF000_0000}),
    .timeout_cycles(T)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbm_adr_i(adr), .wbm_dat_i(mdat), .wbm_sel_i(sel), .wbm_we_i(we),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_cti_i(cti), .wbm_bte_i(bte),
    .wbm_dat_o(m_dat_o), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_o), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
    .wbs_cti_o(s_cti), .wbs_bte_o(s_bte), .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb),
    .wbs_dat_i(sdat), .wbs_ack_i(sack), .wbs_err_i(serr), .wbs_rty_i(srty)
  );

  int tests = 0, fails = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic        cyc;
    logic [1:0]  ack;
    logic [1:0]  e_cyc;
    logic        e_ack, e_err, chk_dat;
    logic [31:0] e_dat;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(logic [31:0] a, logic c, logic [1:0] k, logic [1:0] ec,
                              logic ea, logic ee, logic cd, logic [31:0] ed);
    vec_t v;
    v.adr = a; v.cyc = c; v.ack = k; v.e_cyc = ec;
    v.e_ack = ea; v.e_err = ee; v.chk_dat = cd; v.e_dat = ed;
    return v;
  endfunction

  // Transaction-level reference: which slave owns the cycle, whether an err is owed, and unterminated strobe age.
  logic [31:0] base [2] = '{32'h0000_0000, 32'h1000_0000};
  logic [31:0] mask [2] = '{32'hF000_0000, 32'hF000_0000};
  int owner = -1, age = 0;
  bit perr = 0;

  function automatic int decode(logic [31:0] a);
    for (int i = 0; i < 2; i++)
      if ((a & mask[i]) == (base[i] & mask[i])) return i;
    return -1;
  endfunction

  task automatic model_cycle();
    logic [1:0] ecyc = '0, estb = '0;
    logic eack = 0, eerr = 0, erty = 0;
    logic [31:0] edat = '0;
    int k = owner, nowner = -1, nage = 0;
    bit nperr = 0;
    if (perr) eerr = 1;
    else begin
      if (k < 0 && cyc && stb) begin
        k = decode(adr);
        nperr = k < 0;
      end
      if (k >= 0) begin
        ecyc[k] = cyc; estb[k] = stb;
        eack = sack[k]; eerr = serr[k]; erty = srty[k];
        edat = sdat[k*32 +: 32];
        nage = (stb && !(sack[k] | serr[k] | srty[k])) ? age + 1 : 0;
        nowner = cyc ? k : -1;
        if (nage == T) begin
          nperr = 1; nowner = -1; nage = 0;
        end
      end
    end
    chk("rnd_cyc", s_cyc, ecyc);
    chk("rnd_stb", s_stb, estb);
    chk("rnd_ack", m_ack, eack);
    chk("rnd_err", m_err, eerr);
    chk("rnd_rty", m_rty, erty);
    chk("rnd_dat", m_dat_o, edat);
    chk("rnd_adr_bcast", s_adr, {adr, adr});
    chk("rnd_dat_bcast", s_dat_o, {mdat, mdat});
    owner = nowner; age = nage; perr = nperr;
  endtask

  function automatic logic [31:0] pick();
    int r = $urandom_range(0, 2);
    logic [3:0] top = r == 2 ? 4'($urandom_range(2, 15)) : 4'(r);
    return {top, 28'($urandom)};
  endfunction

  initial begin
    adr = 32'h1000_0000; cyc = 1; stb = 1; sack = 2'b10;
    #12;
    chk("reset_cyc", s_cyc, 2'b00);
    chk("reset_stb", s_stb, 2'b00);
    chk("reset_ack", m_ack, 0);
    chk("reset_err", m_err, 0);
    cyc = 0; stb = 0; sack = 0;
    @(posedge clk); #2 rst_n = 1;

    vq.push_back(mk(32'h1000_0004, 1, 2'b00, 2'b10, 0, 0, 0, 0));
    vq.push_back(mk(32'h1000_0004, 1, 2'b10, 2'b10, 1, 0, 1, 32'hDEADBEEF));
    vq.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 1, 0));
    vq.push_back(mk(32'h2000_0000, 1, 2'b00, 2'b00, 0, 0, 1, 0));
    vq.push_back(mk(32'h2000_0000, 1, 2'b00, 2'b00, 0, 1, 1, 0));
    vq.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 1, 0));
    vq.push_back(mk(32'h0FFF_FFF8, 1, 2'b00, 2'b01, 0, 0, 0, 0));
    vq.push_back(mk(32'h0FFF_FFF8, 1, 2'b01, 2'b01, 1, 0, 1, 32'h5EED));
    vq.push_back(mk(32'h0FFF_FFFC, 1, 2'b01, 2'b01, 1, 0, 1, 32'h5EED));
    vq.push_back(mk(32'h1000_0000, 1, 2'b01, 2'b01, 1, 0, 1, 32'h5EED));
    vq.push_back(mk(32'h1000_0004, 1, 2'b01, 2'b01, 1, 0, 1, 32'h5EED));
    vq.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    for (int i = 0; i < T; i++) vq.push_back(mk(32'h100, 1, 2'b00, 2'b01, 0, 0, 0, 0));
    vq.push_back(mk(32'h100, 1, 2'b00, 2'b00, 0, 1, 1, 0));
    vq.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 1, 0));
    for (int i = 0; i < T - 1; i++) vq.push_back(mk(32'h200, 1, 2'b00, 2'b01, 0, 0, 0, 0));
    vq.push_back(mk(32'h200, 1, 2'b01, 2'b01, 1, 0, 1, 32'h5EED));
    vq.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 1, 0));
    vq.push_back(mk(32'h10, 1, 2'b00, 2'b01, 0, 0, 0, 0));
    vq.push_back(mk(32'h10, 1, 2'b10, 2'b01, 0, 0, 0, 0));
    vq.push_back(mk(32'h10, 1, 2'b01, 2'b01, 1, 0, 1, 32'h5EED));
    vq.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 2'b00, 2'b00, 0, 0, 1, 0));

    foreach (vq[i]) begin
      @(posedge clk);
      #2;
      adr = vq[i].adr; cyc = vq[i].cyc; stb = vq[i].cyc; sack = vq[i].ack;
      cti = vq[i].cyc ? 3'b010 : 3'b000;
      #2;
      chk($sformatf("row%0d_cyc", i), s_cyc, vq[i].e_cyc);
      chk($sformatf("row%0d_stb", i), s_stb, vq[i].e_cyc);
      chk($sformatf("row%0d_ack", i), m_ack, vq[i].e_ack);
      chk($sformatf("row%0d_err", i), m_err, vq[i].e_err);
      if (vq[i].chk_dat) chk($sformatf("row%0d_dat", i), m_dat_o, vq[i].e_dat);
    end

    @(posedge clk); #2 adr = 32'h40; cyc = 1; stb = 1; sack = 0;
    #2 chk("rst_mid_cyc_pre", s_cyc, 2'b01);
    @(posedge clk); #2 sack = 2'b01;
    #2 chk("rst_mid_ack_pre", m_ack, 1);
    #1 rst_n = 0;
    #1;
    chk("rst_mid_cyc", s_cyc, 2'b00);
    chk("rst_mid_stb", s_stb, 2'b00);
    chk("rst_mid_ack", m_ack, 0);
    @(posedge clk); #2 cyc = 0; stb = 0; sack = 0; rst_n = 1;
    @(posedge clk); #2 adr = 32'h1000_0000; cyc = 1; stb = 1;
    #2 chk("post_rst_cyc", s_cyc, 2'b10);
    @(posedge clk); #2 sack = 2'b10;
    #2 chk("post_rst_ack", m_ack, 1);
    @(posedge clk); #2 cyc = 0; stb = 0; sack = 0;
    @(posedge clk);

    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #2;
      if (!cyc) begin
        cyc = 1'($urandom_range(0, 1));
        stb = cyc;
        if (cyc) adr = pick();
      end else if ($urandom_range(0, 19) == 0) begin
        cyc = 0; stb = 0;
      end else begin
        stb = $urandom_range(0, 3) != 0;
        if ($urandom_range(0, 3) == 0) adr = pick();
      end
      mdat = $urandom; sel = 4'($urandom); we = 1'($urandom);
      cti = 3'($urandom); bte = 2'($urandom);
      sdat = {32'($urandom), 32'($urandom)};
      for (int s = 0; s < 2; s++) begin
        sack[s] = $urandom_range(0, 9) == 0;
        serr[s] = $urandom_range(0, 29) == 0;
        srty[s] = $urandom_range(0, 29) == 0;
      end
      #2 model_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
